// File: rtl/ram_block_mover.sv
// ram_block_mover: initiator on a single-port RAM (cl/st/ad/X/Y).
// Runs one block command at a time: COPY (read src, write dst, 3 cycles/word)
// or FILL (write pattern to dst, 1 cycle/word). Every output is registered.
module ram_block_mover #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          cl,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
  output logic          st,
  output logic [AW-1:0] ad,
  output logic [DW-1:0] X,
  input  logic [DW-1:0] Y
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_mode,  w_mode_nxt;
  logic [AW-1:0] r_src,   w_src_nxt;
  logic [AW-1:0] r_dst,   w_dst_nxt;
  logic [AW-1:0] r_len,   w_len_nxt;
  logic [AW-1:0] r_count, w_count_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          r_done,  w_done_nxt;
  logic          r_st,    w_st_nxt;
  logic [AW-1:0] r_ad,    w_ad_nxt;
  logic [DW-1:0] r_x,     w_x_nxt;
  logic [AW-1:0] w_cnt_inc;

  // Word index after the current write; addresses wrap naturally at AW bits.
  assign w_cnt_inc = r_count + AW'(1);

  // Next-state and next-output decode; every register holds unless a state says otherwise.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_len_nxt   = r_len;
    w_count_nxt = r_count;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_st_nxt    = 1'b0;
    w_ad_nxt    = r_ad;
    w_x_nxt     = r_x;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_mode_nxt  = mode;
          w_src_nxt   = src;
          w_dst_nxt   = dst;
          w_len_nxt   = len;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b1;
          if (len == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else if (!mode) begin
            // COPY: present the first source address during RD.
            w_state_nxt = S_RD;
            w_ad_nxt    = src;
          end else begin
            // FILL: go straight to writing; X keeps the pattern for the whole command.
            w_state_nxt = S_WR;
            w_ad_nxt    = dst;
            w_x_nxt     = pattern;
            w_st_nxt    = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        // RAM samples ad at the end of this cycle.
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Y now carries mem[src+count]; turn it around into a write.
        w_state_nxt = S_WR;
        w_x_nxt     = Y;
        w_ad_nxt    = r_dst + r_count;
        w_st_nxt    = 1'b1;
      end
      S_WR: begin
        w_count_nxt = w_cnt_inc;
        if (w_cnt_inc == r_len) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else if (!r_mode) begin
          w_state_nxt = S_RD;
          w_ad_nxt    = r_src + w_cnt_inc;
        end else begin
          // Back-to-back FILL: st stays high, only the address advances.
          w_state_nxt = S_WR;
          w_ad_nxt    = r_dst + w_cnt_inc;
          w_st_nxt    = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears st asynchronously so a pending write is dropped.
  always_ff @(posedge cl or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_st    <= 1'b0;
      r_ad    <= '0;
      r_x     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_len   <= w_len_nxt;
      r_count <= w_count_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_st    <= w_st_nxt;
      r_ad    <= w_ad_nxt;
      r_x     <= w_x_nxt;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;
  assign st    = r_st;
  assign ad    = r_ad;
  assign X     = r_x;

endmodule
